// File: rtl/xadc_pkg.sv
// Shared types and widths for the XADC DRP arbiter.
package xadc_pkg;

    localparam int unsigned DRP_ADDR_W = 7;
    localparam int unsigned DRP_DATA_W = 16;

    localparam logic [DRP_ADDR_W-1:0] DEFAULT_SAMPLE_ADDR = 7'h1F;

    typedef enum logic [1:0] {
        StIdle,
        StSampleWait,
        StHostWait
    } state_e;

endpackage

// File: rtl/xadc_drp_arbiter.sv
// Shares one XADC DRP port between automatic end-of-conversion sample reads and
// host register accesses, with round-robin arbitration and a per-access timeout.
module xadc_drp_arbiter
    import xadc_pkg::*;
#(
    parameter logic [DRP_ADDR_W-1:0] SAMPLE_ADDR    = DEFAULT_SAMPLE_ADDR,
    parameter int unsigned           TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  eoc,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [DRP_ADDR_W-1:0] host_addr,
    input  logic [DRP_DATA_W-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DRP_DATA_W-1:0] host_rdata,
    output logic                  host_err,
    output logic                  sample_valid,
    output logic [DRP_DATA_W-1:0] sample_data,
    output logic                  sample_err,
    output logic                  drp_den,
    output logic                  drp_dwe,
    output logic [DRP_ADDR_W-1:0] drp_daddr,
    output logic [DRP_DATA_W-1:0] drp_di,
    input  logic                  drp_drdy,
    input  logic [DRP_DATA_W-1:0] drp_do,
    output logic                  busy
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic                    last_host_q, last_host_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    den_q, den_d;
    logic                    dwe_q, dwe_d;
    logic [DRP_ADDR_W-1:0]   daddr_q, daddr_d;
    logic [DRP_DATA_W-1:0]   di_q, di_d;
    logic                    host_ack_q, host_ack_d;
    logic [DRP_DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                    host_err_q, host_err_d;
    logic                    sample_valid_q, sample_valid_d;
    logic [DRP_DATA_W-1:0]   sample_data_q, sample_data_d;
    logic                    sample_err_q, sample_err_d;

    logic sample_req, host_req_eff, grant_sample, grant_host;

    // An eoc in IDLE competes immediately; the host request is masked during
    // its own ack cycle because the host only drops it after seeing the ack.
    assign sample_req   = pending_q | eoc;
    assign host_req_eff = host_req & ~host_ack_q;

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        last_host_d    = last_host_q;
        cnt_d          = cnt_q;
        den_d          = 1'b0;
        dwe_d          = dwe_q;
        daddr_d        = daddr_q;
        di_d           = di_q;
        host_ack_d     = 1'b0;
        host_rdata_d   = host_rdata_q;
        host_err_d     = 1'b0;
        sample_valid_d = 1'b0;
        sample_data_d  = sample_data_q;
        sample_err_d   = 1'b0;
        grant_sample   = 1'b0;
        grant_host     = 1'b0;

        case (state_q)
            StIdle: begin
                if (sample_req && (!host_req_eff || last_host_q)) begin
                    grant_sample = 1'b1;
                end else if (host_req_eff) begin
                    grant_host = 1'b1;
                end
            end
            StSampleWait: begin
                if (drp_drdy) begin
                    sample_valid_d = 1'b1;
                    sample_data_d  = drp_do;
                    state_d        = StIdle;
                end else if (cnt_q == CntLast) begin
                    sample_err_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHostWait: begin
                if (drp_drdy) begin
                    host_ack_d   = 1'b1;
                    host_rdata_d = drp_do;
                    state_d      = StIdle;
                end else if (cnt_q == CntLast) begin
                    host_ack_d   = 1'b1;
                    host_err_d   = 1'b1;
                    host_rdata_d = '0;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (grant_sample) begin
            den_d       = 1'b1;
            dwe_d       = 1'b0;
            daddr_d     = SAMPLE_ADDR;
            cnt_d       = '0;
            last_host_d = 1'b0;
            state_d     = StSampleWait;
        end else if (grant_host) begin
            den_d       = 1'b1;
            dwe_d       = host_we;
            daddr_d     = host_addr;
            di_d        = host_wdata;
            cnt_d       = '0;
            last_host_d = 1'b1;
            state_d     = StHostWait;
        end

        // An eoc that itself won the grant is consumed; one arriving while an
        // older request is granted re-arms pending without an overrun.
        if (grant_sample) begin
            pending_d = pending_q & eoc;
        end else if (eoc) begin
            if (pending_q) begin
                sample_err_d = 1'b1;
            end
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            pending_q      <= 1'b0;
            last_host_q    <= 1'b1;
            cnt_q          <= '0;
            den_q          <= 1'b0;
            dwe_q          <= 1'b0;
            daddr_q        <= '0;
            di_q           <= '0;
            host_ack_q     <= 1'b0;
            host_rdata_q   <= '0;
            host_err_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            last_host_q    <= last_host_d;
            cnt_q          <= cnt_d;
            den_q          <= den_d;
            dwe_q          <= dwe_d;
            daddr_q        <= daddr_d;
            di_q           <= di_d;
            host_ack_q     <= host_ack_d;
            host_rdata_q   <= host_rdata_d;
            host_err_q     <= host_err_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            sample_err_q   <= sample_err_d;
        end
    end

    assign drp_den      = den_q;
    assign drp_dwe      = dwe_q;
    assign drp_daddr    = daddr_q;
    assign drp_di       = di_q;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign host_err     = host_err_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign sample_err   = sample_err_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: doc/xadc_drp_arbiter.md
XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

Interface
REQ-001 Parameter SAMPLE_ADDR, default 7'h1F, is the DRP address read on every end-of-conversion.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, is the maximum cycles to wait for drp_drdy after drp_den.
REQ-003 clk  in  1  single clock for all logic; the XADC DRP clock is the same clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 eoc  in  1  end-of-conversion pulse from the XADC.
REQ-006 host_req  in  1  host access request, level, held until host_ack.
REQ-007 host_we  in  1  1 = write, 0 = read; sampled on grant.
REQ-008 host_addr  in  7  host DRP address; sampled on grant.
REQ-009 host_wdata  in  16  host write data; sampled on grant.
REQ-010 host_ack  out  1  one-cycle completion pulse for the host access.
REQ-011 host_rdata  out  16  read data, valid with host_ack.
REQ-012 host_err  out  1  timeout flag, valid with host_ack.
REQ-013 sample_valid  out  1  one-cycle pulse, sample_data is new.
REQ-014 sample_data  out  16  last sample read from SAMPLE_ADDR.
REQ-015 sample_err  out  1  one-cycle pulse on eoc overrun or sample timeout.
REQ-016 drp_den, drp_dwe  out  1 each  DRP enable and write-enable to the XADC.
REQ-017 drp_daddr  out  7;  drp_di  out  16  DRP address and write data.
REQ-018 drp_drdy  in  1;  drp_do  in  16  DRP ready and read data.
REQ-019 busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 States SHALL be IDLE, SAMPLE_WAIT and HOST_WAIT.
REQ-021 A cycle with eoc=1 SHALL set sample_pending; eoc while sample_pending is already 1 SHALL pulse sample_err with sample_pending remaining 1.
REQ-022 In IDLE, if exactly one of sample_pending or host_req is set, that requester SHALL be granted.
REQ-023 If both are set, the grant SHALL go round-robin: to the requester not granted last.
REQ-024 On grant at cycle N, drp_den SHALL be 1 for exactly cycle N+1, with daddr, dwe and di registered.
REQ-025 Sample grant: daddr=SAMPLE_ADDR, dwe=0; clear sample_pending; go to SAMPLE_WAIT.
REQ-026 Host grant: daddr=host_addr, dwe=host_we, di=host_wdata; go to HOST_WAIT.
REQ-027 When drp_drdy=1 in a WAIT state at cycle M, the block SHALL, at M+1, pulse sample_valid with sample_data=drp_do, or pulse host_ack with host_rdata=drp_do and host_err=0, and return to IDLE.
REQ-028 Host writes SHALL return host_rdata = drp_do as presented.
REQ-029 The earliest next drp_den after drdy at cycle M SHALL be at M+2.
REQ-030 The wait counter SHALL clear on grant; if it reaches TIMEOUT_CYCLES without drdy, the block SHALL return to IDLE.
REQ-031 On a host timeout: pulse host_ack with host_err=1 and host_rdata=0.
REQ-032 On a sample timeout: pulse sample_err, leave sample_data unchanged, no sample_valid.
REQ-033 drp_drdy in IDLE SHALL be ignored.
REQ-034 drdy and timeout in the same cycle SHALL be treated as drdy.
REQ-035 eoc in the same cycle as a sample grant SHALL re-set sample_pending, with no overrun flagged.
REQ-036 drp_den SHALL never be high in two consecutive cycles.
REQ-037 A new drp_den SHALL never be issued while in a WAIT state.

Reset
REQ-038 Reset SHALL force state IDLE and clear sample_pending and the wait counter.
REQ-039 Reset SHALL set the last grant to host, so sample wins the first tie.
REQ-040 Reset SHALL drive all outputs to 0.
REQ-041 Reset mid-transaction SHALL abort the transaction without host_ack or sample_valid, and a late drdy SHALL then be ignored.

Structure
REQ-042 Package xadc_pkg SHALL hold the state enum, DRP_ADDR_W=7, DRP_DATA_W=16 and the default SAMPLE_ADDR.
REQ-043 The block SHALL be flat, with no sub-module; the timeout counter is inline.

Verification
REQ-044 Scenario: eoc pulse, drdy 3 cycles after den with drp_do=16'h8000 -> drp_daddr=7'h1F, sample_valid one cycle, sample_data=16'h8000.
REQ-045 Scenario: host read addr 7'h41, drp_do=16'h1234 -> host_ack, host_rdata=16'h1234, host_err=0, drp_dwe=0.
REQ-046 Scenario: eoc and host_req in the same cycle after reset -> sample granted first, host second, and the next tie goes to sample again.
REQ-047 Scenario: host write with no drdy, TIMEOUT_CYCLES=8 -> host_ack with host_err=1 eight cycles after den, state IDLE.
REQ-048 Scenario: two eoc pulses while in HOST_WAIT -> one sample_err pulse, and exactly one sample read follows.
REQ-049 Scenario: reset asserted in SAMPLE_WAIT, then drdy -> no sample_valid, all outputs 0, busy=0.
